// File: rtl/io_map_pkg.sv
// Shared constants, encodings and helpers for the io_mapper scan sequencer.
package io_map_pkg;

  // Drive words written to the mapper for each scan step, plus the release word.
  localparam logic [31:0] DRV_STEP0   = 32'h0000_0000;
  localparam logic [31:0] DRV_STEP1   = 32'h0000_0005;
  localparam logic [31:0] DRV_STEP2   = 32'h0000_0004;
  localparam logic [31:0] DRV_STEP3   = 32'h0000_000A;
  localparam logic [31:0] DRV_RELEASE = 32'h0000_0000;

  // Per-line classification codes.
  localparam logic [1:0] CLS_LOW  = 2'b00;
  localparam logic [1:0] CLS_TOG  = 2'b01;
  localparam logic [1:0] CLS_NONE = 2'b10;
  localparam logic [1:0] CLS_HIGH = 2'b11;

  // Host register map.
  localparam logic [3:0] HREG_CSR   = 4'h0;
  localparam logic [3:0] HREG_RES01 = 4'h2;
  localparam logic [3:0] HREG_RES23 = 4'h3;

  // Mapper register map.
  localparam logic [3:0] MADDR_DRIVE = 4'h0;
  localparam logic [3:0] MADDR_ARM   = 4'h8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DRIVE   = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_ARM     = 4'd3,
    ST_WAIT    = 4'd4,
    ST_READ    = 4'd5,
    ST_NEXT    = 4'd6,
    ST_RELEASE = 4'd7,
    ST_DONE    = 4'd8
  } seq_state_e;

  function automatic logic [31:0] drive_word(input logic [1:0] step);
    case (step)
      2'd0:    return DRV_STEP0;
      2'd1:    return DRV_STEP1;
      2'd2:    return DRV_STEP2;
      2'd3:    return DRV_STEP3;
      default: return DRV_RELEASE;
    endcase
  endfunction

  // A line that never went low is high; one that never went high is low.
  function automatic logic [1:0] classify(input logic [15:0] hi, input logic [15:0] lo);
    if (lo == 16'h0000) begin
      return CLS_HIGH;
    end else if (hi == 16'h0000) begin
      return CLS_LOW;
    end else begin
      return CLS_TOG;
    end
  endfunction

endpackage

// File: rtl/io_map_sequencer_if.sv
// Simple Wishbone-style single-transaction bus used for both host and mapper ports.
interface io_map_sequencer_if;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        cyc;
  logic        ack;

  modport master (output addr, output wdata, output we, output cyc, input rdata, input ack);
  modport slave  (input addr, input wdata, input we, input cyc, output rdata, output ack);
endinterface

// File: rtl/io_map_wb_master.sv
// Single-transaction bus master toward the mapper. Holds the request stable
// until ack and leaves the bus idle for at least one cycle between transactions.
module io_map_wb_master
  import io_map_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [3:0]                addr,
  input  logic                      we,
  input  logic [31:0]               wdata,
  output logic                      done,
  output logic [31:0]               rdata,
  io_map_sequencer_if.master        m
);

  logic        cyc_q,   cyc_d;
  logic        we_q,    we_d;
  logic [3:0]  addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q,  done_d;
  logic [31:0] rdata_q, rdata_d;

  assign m.cyc   = cyc_q;
  assign m.we    = we_q;
  assign m.addr  = addr_q;
  assign m.wdata = wdata_q;
  assign done    = done_q;
  assign rdata   = rdata_q;

  // Launch a request when idle (not in the done cycle), finish on ack.
  always_comb begin
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    if (cyc_q) begin
      if (m.ack) begin
        cyc_d   = 1'b0;
        done_d  = 1'b1;
        rdata_d = m.rdata;
      end else begin
        cyc_d   = 1'b1;
      end
    end else if (req && !done_q) begin
      cyc_d   = 1'b1;
      we_d    = we;
      addr_d  = addr;
      wdata_d = wdata;
    end else begin
      cyc_d   = 1'b0;
    end
  end

  // Bus-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 4'h0;
      wdata_q <= 32'h0;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/io_map_sequencer.sv
// Scan controller: drives the io_mapper through four drive steps, reads the
// hi/lo counters for each line and exposes a 64-bit class map to the host.
module io_map_sequencer
  import io_map_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int WINDOW_CYCLES = 600000
) (
  input  logic               clk,
  input  logic               rst,
  io_map_sequencer_if.slave  wb,
  io_map_sequencer_if.master m
);

  localparam logic [19:0] SETTLE_LOAD = 20'(SETTLE_CYCLES - 1);
  localparam logic [19:0] WINDOW_LOAD = 20'(WINDOW_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [1:0]  step_q,  step_d;
  logic [2:0]  idx_q,   idx_d;
  logic [19:0] cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        abort_q, abort_d;
  logic [63:0] res_q,   res_d;
  logic        wb_ack_q,   wb_ack_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;

  logic        host_acc_s, start_s, abort_s;
  logic [31:0] rd_mux_s;
  logic        mreq_s, mwe_s, mdone_s;
  logic [3:0]  maddr_s;
  logic [31:0] mwdata_s, mrdata_s;
  logic        unused_wdata_s;

  assign wb.ack   = wb_ack_q;
  assign wb.rdata = wb_rdata_q;

  assign host_acc_s     = wb.cyc & ~wb_ack_q;
  assign start_s        = host_acc_s & wb.we & (wb.addr == HREG_CSR) & wb.wdata[0] & ~busy_q;
  assign abort_s        = host_acc_s & wb.we & (wb.addr == HREG_CSR) & wb.wdata[1] & busy_q;
  assign unused_wdata_s = ^wb.wdata[31:2];

  io_map_wb_master u_master (
    .clk   (clk),
    .rst   (rst),
    .req   (mreq_s),
    .addr  (maddr_s),
    .we    (mwe_s),
    .wdata (mwdata_s),
    .done  (mdone_s),
    .rdata (mrdata_s),
    .m     (m)
  );

  // Select the host register being read.
  always_comb begin
    case (wb.addr)
      HREG_CSR:   rd_mux_s = {28'h0, step_q, done_q, busy_q};
      HREG_RES01: rd_mux_s = res_q[31:0];
      HREG_RES23: rd_mux_s = res_q[63:32];
      default:    rd_mux_s = 32'h0;
    endcase
  end

  // Host ack and read data; data is zero outside a read ack.
  always_comb begin
    wb_ack_d = host_acc_s;
    if (host_acc_s && !wb.we) begin
      wb_rdata_d = rd_mux_s;
    end else begin
      wb_rdata_d = 32'h0;
    end
  end

  // Mapper request issued by each bus-owning state.
  always_comb begin
    mreq_s   = 1'b0;
    maddr_s  = MADDR_DRIVE;
    mwe_s    = 1'b0;
    mwdata_s = 32'h0;
    case (state_q)
      ST_DRIVE:   begin mreq_s = 1'b1; mwe_s = 1'b1; mwdata_s = drive_word(step_q); end
      ST_ARM:     begin mreq_s = 1'b1; mwe_s = 1'b1; maddr_s = MADDR_ARM; end
      ST_READ:    begin mreq_s = 1'b1; maddr_s = {1'b0, idx_q}; end
      ST_RELEASE: begin mreq_s = 1'b1; mwe_s = 1'b1; mwdata_s = DRV_RELEASE; end
      default:    begin mreq_s = 1'b0; end
    endcase
  end

  // Scan sequencing; an abort in a bus state waits for the in-flight transaction.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    abort_d = abort_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_DRIVE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          abort_d = 1'b0;
          step_d  = 2'd0;
          idx_d   = 3'd0;
          res_d   = {32{CLS_NONE}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE, ST_ARM: begin
        if (mdone_s) begin
          if (abort_q || abort_s) begin
            state_d = ST_RELEASE;
          end else if (state_q == ST_DRIVE) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WINDOW_LOAD;
          end
        end else if (abort_s) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
      end
      ST_SETTLE, ST_WAIT: begin
        if (abort_s) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == 20'd0) begin
          state_d = (state_q == ST_SETTLE) ? ST_ARM : ST_READ;
          idx_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q - 20'd1;
        end
      end
      ST_READ: begin
        if (mdone_s) begin
          res_d[{step_q, idx_q, 1'b0} +: 2] = classify(mrdata_s[31:16], mrdata_s[15:0]);
          if (abort_q || abort_s) begin
            state_d = ST_RELEASE;
          end else if (idx_q == 3'd7) begin
            state_d = ST_NEXT;
          end else begin
            idx_d   = idx_q + 3'd1;
          end
        end else if (abort_s) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
      end
      ST_NEXT: begin
        if (abort_s || step_q == 2'd3) begin
          state_d = ST_RELEASE;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_RELEASE: begin
        if (mdone_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller and host-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      step_q     <= 2'd0;
      idx_q      <= 3'd0;
      cnt_q      <= 20'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      res_q      <= {32{CLS_NONE}};
      wb_ack_q   <= 1'b0;
      wb_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      res_q      <= res_d;
      wb_ack_q   <= wb_ack_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

endmodule

// File: tb/tb_io_map_sequencer.sv
// Directed bench for io_map_sequencer with a scripted behavioral mapper.
module tb_io_map_sequencer;
  import io_map_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_map_sequencer_if host();
  io_map_sequencer_if map();

  io_map_sequencer #(.SETTLE_CYCLES(4), .WINDOW_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (host),
    .m   (map)
  );

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int wait_cnt = 0;
  int arm_total = 0, arm_base = 0, rd_total = 0, rd_base = 0, wr_base = 0;
  int viol = 0;
  logic cyc_prev = 1'b0, ack_prev = 1'b0;
  logic [35:0] wlog[$];
  logic [15:0] hi_s [4][8];
  logic [15:0] lo_s [4][8];
  logic [3:0]  ea [9];
  logic [31:0] ed [9];

  // Behavioral mapper: ack after lat cycles, log writes, return scripted counts.
  always @(posedge clk) begin
    cyc_prev <= map.cyc;
    ack_prev <= map.ack;
    if (!rst && cyc_prev && ack_prev && map.cyc) viol <= viol + 1;
    if (!rst && cyc_prev && !ack_prev && !map.cyc) viol <= viol + 1;
    if (rst) begin
      map.ack   <= 1'b0;
      map.rdata <= 32'h0;
      wait_cnt  <= 0;
    end else if (map.cyc && !map.ack) begin
      if (wait_cnt >= lat - 1) begin
        map.ack  <= 1'b1;
        wait_cnt <= 0;
        if (map.we) begin
          wlog.push_back({map.addr, map.wdata});
          if (map.addr == MADDR_ARM) arm_total <= arm_total + 1;
          map.rdata <= 32'h0;
        end else begin
          rd_total  <= rd_total + 1;
          map.rdata <= {hi_s[2'(arm_total - arm_base - 1)][map.addr[2:0]],
                        lo_s[2'(arm_total - arm_base - 1)][map.addr[2:0]]};
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      map.ack  <= 1'b0;
      wait_cnt <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    host.addr = a; host.wdata = d; host.we = 1'b1; host.cyc = 1'b1;
    @(negedge clk);
    host.cyc = 1'b0; host.we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    host.addr = a; host.we = 1'b0; host.cyc = 1'b1;
    @(negedge clk);
    d = host.rdata;
    host.cyc = 1'b0;
  endtask

  task automatic set_script(input logic [15:0] hi_o, input logic [15:0] lo_o,
                            input logic [15:0] hi_3, input logic [15:0] lo_3);
    for (int s = 0; s < 4; s++) begin
      for (int l = 0; l < 8; l++) begin
        hi_s[s][l] = (l == 3) ? hi_3 : hi_o;
        lo_s[s][l] = (l == 3) ? lo_3 : lo_o;
      end
    end
  endtask

  task automatic start_scan();
    wr_base = wlog.size(); arm_base = arm_total; rd_base = rd_total;
    host_write(HREG_CSR, 32'h1);
  endtask

  task automatic wait_idle(output logic [31:0] csr);
    csr = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      host_read(HREG_CSR, csr);
      if (csr[1:0] == 2'b10) break;
    end
  endtask

  task automatic wait_arms(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (arm_total - arm_base >= n) break;
    end
  endtask

  task automatic check_writes(input string tag, input int n);
    check_eq({tag, "_nwr"}, 32'(wlog.size() - wr_base), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (wr_base + k < wlog.size()) begin
        check_eq({tag, "_waddr"}, 32'(wlog[wr_base + k][35:32]), 32'(ea[k]));
        if (ea[k] == MADDR_DRIVE) check_eq({tag, "_wdata"}, wlog[wr_base + k][31:0], ed[k]);
      end
    end
  endtask

  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    host.cyc = 1'b0; host.we = 1'b0; host.addr = 4'h0; host.wdata = 32'h0;
    set_script(16'h1234, 16'h0000, 16'h1234, 16'h0000);
    ea = '{4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0};
    ed = '{32'h0, 32'h0, 32'h5, 32'h0, 32'h4, 32'h0, 32'hA, 32'h0, 32'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_wb_ack",   32'(host.ack), 32'h0);
    check_eq("rst_wb_rdata", host.rdata, 32'h0);
    check_eq("rst_m_cyc",    32'(map.cyc), 32'h0);
    check_eq("rst_m_we",     32'(map.we), 32'h0);
    check_eq("rst_m_addr",   32'(map.addr), 32'h0);
    check_eq("rst_m_wdata",  map.wdata, 32'h0);
    rst = 1'b0;
    host_read(HREG_CSR, rd);   check_eq("rst_csr", rd, 32'h0);
    host_read(HREG_RES01, rd); check_eq("rst_res01", rd, 32'hAAAAAAAA);
    host_read(HREG_RES23, rd); check_eq("rst_res23", rd, 32'hAAAAAAAA);
    host_read(4'h7, rd);       check_eq("rst_unmapped", rd, 32'h0);

    // 1: every line high in every step
    start_scan();
    wait_idle(rd);             check_eq("s1_csr", rd, 32'hE);
    host_read(HREG_RES01, rd); check_eq("s1_res01", rd, 32'hFFFFFFFF);
    host_read(HREG_RES23, rd); check_eq("s1_res23", rd, 32'hFFFFFFFF);
    check_writes("s1", 9);
    check_eq("s1_nrd", 32'(rd_total - rd_base), 32'd32);

    // 2: line 3 toggling, others low
    set_script(16'h0000, 16'h0009, 16'h0005, 16'h0007);
    start_scan();
    wait_idle(rd);             check_eq("s2_csr", rd, 32'hE);
    host_read(HREG_RES01, rd); check_eq("s2_res01", rd, 32'h00400040);
    host_read(HREG_RES23, rd); check_eq("s2_res23", rd, 32'h00400040);

    // 3: abort during step1 window
    set_script(16'h1234, 16'h0000, 16'h1234, 16'h0000);
    start_scan();
    wait_arms(2);
    repeat (3) @(negedge clk);
    host_write(HREG_CSR, 32'h2);
    wait_idle(rd);             check_eq("s3_csr", rd, 32'h6);
    host_read(HREG_RES01, rd); check_eq("s3_res01", rd, 32'hAAAAFFFF);
    host_read(HREG_RES23, rd); check_eq("s3_res23", rd, 32'hAAAAAAAA);
    ea[4] = 4'h0; ed[4] = 32'h0;
    check_writes("s3", 5);
    check_eq("s3_nrd", 32'(rd_total - rd_base), 32'd8);
    ed[4] = 32'h4;

    // 4: start while busy is ignored
    set_script(16'h0000, 16'h0009, 16'h0005, 16'h0007);
    start_scan();
    wait_arms(1);
    host_write(HREG_CSR, 32'h1);
    wait_idle(rd);             check_eq("s4_csr", rd, 32'hE);
    host_read(HREG_RES01, rd); check_eq("s4_res01", rd, 32'h00400040);
    check_writes("s4", 9);
    check_eq("s4_nrd", 32'(rd_total - rd_base), 32'd32);

    // 5: reset during READ idx 4
    start_scan();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((rd_total - rd_base == 4) && map.cyc) break;
    end
    check_eq("s5_cyc_before", 32'(map.cyc), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("s5_cyc_in_rst", 32'(map.cyc), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    host_read(HREG_CSR, rd);   check_eq("s5_csr", rd, 32'h0);
    host_read(HREG_RES01, rd); check_eq("s5_res01", rd, 32'hAAAAAAAA);
    host_read(HREG_RES23, rd); check_eq("s5_res23", rd, 32'hAAAAAAAA);

    // 6: slow mapper ack
    lat = 3;
    set_script(16'h1234, 16'h0000, 16'h1234, 16'h0000);
    start_scan();
    wait_idle(rd);             check_eq("s6_csr", rd, 32'hE);
    host_read(HREG_RES01, rd); check_eq("s6_res01", rd, 32'hFFFFFFFF);
    host_read(HREG_RES23, rd); check_eq("s6_res23", rd, 32'hFFFFFFFF);
    check_writes("s6", 9);
    check_eq("s6_nrd", 32'(rd_total - rd_base), 32'd32);
    check_eq("bus_protocol_viol", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_map_sequencer.md
# io_map_sequencer

Automatic scan controller for the `io_mapper` pin-identification block. It owns the mapper's Wishbone port as a bus master and runs a fixed four-step drive sequence: float, weak-high, weak-low, strong-high. For each step it opens one sense window, reads all eight hi/lo counter pairs and reduces each line to a 2-bit class. A Wishbone slave on the SoC bus starts and aborts scans and returns the 64-bit result map.

## Interface
Parameters:
- `SETTLE_CYCLES`, 64: wait after each drive write before arming sense.
- `WINDOW_CYCLES`, 600000: wait after arming; must exceed the mapper window (65535 ticks × 9 clk).

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_addr`  in  4  host register address.
- `wb_rdata`  out  32  host read data; zero when not acking a read.
- `wb_wdata`  in  32  host write data.
- `wb_we`  in  1  host write enable.
- `wb_cyc`  in  1  host cycle.
- `wb_ack`  out  1  host ack, `wb_cyc & ~wb_ack`, registered.
- `m_addr`  out  4  mapper address.
- `m_wdata`  out  32  mapper write data.
- `m_we`  out  1  mapper write enable.
- `m_cyc`  out  1  mapper cycle.
- `m_rdata`  in  32  mapper read data, `{hi[15:0], lo[15:0]}`.
- `m_ack`  in  1  mapper ack.

## Operation
Host registers:
- 0x0 CSR, write:
  - bit0 start: ignored while busy.
  - bit1 abort: ignored when idle.
- 0x0 CSR, read:
  - bit0 busy; bit1 done; [3:2] current step.
- 0x2 RES01: step0 lines 0..7 at [15:0], 2 bits per line (line n at [2n+1:2n]); step1 at [31:16].
- 0x3 RES23: same layout, steps 2 and 3.
- Other addresses read 0; writes to them are ignored.

Drive words per step, written to mapper address 0:
- step0 = 0x0
- step1 = 0x5
- step2 = 0x4
- step3 = 0xA
- release = 0x0

Line class from counts:
- lo==0 → 2'b11 (high).
- hi==0 → 2'b00 (low).
- Otherwise 2'b01 (toggling).
- 2'b10 = not measured.

Start: clears done, sets all results to 2'b10, sets busy, enters the FSM.

FSM:
- IDLE → DRIVE on start.
- DRIVE: write the step's drive word → SETTLE.
- SETTLE: count SETTLE_CYCLES → ARM.
- ARM: write mapper address 8 (any data), which starts the sense window → WAIT.
- WAIT: count WINDOW_CYCLES → READ, idx=0.
- READ: read mapper address idx, classify, store the result; idx 7 → NEXT.
- NEXT: step<3 → step+1, DRIVE; step==3 → RELEASE.
- RELEASE: write 0x0 → DONE.
- DONE: done=1, busy=0 → IDLE.

Abort:
- Any state other than IDLE/DONE/RELEASE goes to RELEASE once the in-flight mapper transaction acks.
- Results not yet measured stay 2'b10.
- done is set after an abort.

## Timing
- Mapper transaction (`m_cyc`, `m_we` and `m_addr` held constant throughout):
  - `m_cyc` rises at cycle t.
  - `m_ack` arrives at t+1 (model any latency ≥1).
  - `m_rdata` is sampled in the ack cycle.
  - `m_cyc` is low at the next edge, with at least one idle cycle between transactions.
- Classification and result write occur in the cycle after the ack.
- SETTLE and WAIT counters use a 20-bit down-counter; the exit occurs exactly N cycles after entry.
- Reset values:
  - `wb_ack`, `wb_rdata`: 0.
  - `m_cyc`, `m_we`, `m_addr`, `m_wdata`: 0.
  - busy=0, done=0, results all 2'b10.
- Reset asserted mid-scan: `m_cyc` drops immediately and the state returns to IDLE. The mapper drive state is not released; software rescans or the mapper reset covers it.
- Host CSR read in the same cycle the FSM sets done returns the pre-update value.
- A start written in the DONE cycle is ignored; busy is still 1 in that cycle.

## Structure
- Shared package `io_map_pkg`:
  - Step drive words.
  - Class codes.
  - Host register addresses.
  - Mapper addresses (DRIVE=0, ARM=8).
  - FSM state encoding.
- Sub-module `io_map_wb_master`:
  - Single-transaction engine: req/addr/we/wdata in; done/rdata out.
  - Owns the `m_*` handshake and the idle-gap rule.
  - The top-level FSM only issues requests.

## Test plan
Bench uses a behavioral mapper model (ack at t+1, scripted hi/lo counts) and SETTLE=4, WINDOW=32.
1. Start with all lines lo=0x0000, hi=0x1234 in every step → RES01=RES23=0xFFFFFFFF; done=1; mapper saw writes 0x0,8,0x5,8,0x4,8,0xA,8,0x0 in that order.
2. Line 3 hi=5 lo=7; others hi=0 lo=9 → every step's line-3 field = 2'b01, others 2'b00; RES01=0x00400040.
3. Abort written during step1 WAIT → next mapper write is 0x0 at address 0; RES23=0xAAAAAAAA; step1 fields =0xAAAA; done=1, busy=0.
4. Start written while busy → scan completes unchanged; exactly 9 writes and 32 reads seen.
5. Reset asserted during READ idx=4 → `m_cyc`=0 in the same cycle; CSR reads 0; results 0xAAAAAAAA.
6. Mapper ack delayed 3 cycles → identical results to scenario 1; `m_cyc` stays high until the ack, with one idle gap after.
